// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer in front of datamemory: one access at a time, registered load data.
// Build option DMEM_ARB_RR_EN selects round-robin conflict resolution instead of fixed port-0 priority.
module dmem_port_arbiter #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DM_ADDRESS-1:0] addr0,
  input  logic [DM_ADDRESS-1:0] addr1,
  input  logic [DATA_W-1:0]     wdata0,
  input  logic [DATA_W-1:0]     wdata1,
  input  logic [2:0]            f3_0,
  input  logic [2:0]            f3_1,
  output logic                  ready0,
  output logic                  ready1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_W-1:0]     rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd,
  output logic [1:0]            dbg_state,
  output logic                  dbg_last_gnt
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  gnt_q, gnt_d;
  logic                  we_q, we_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [2:0]            f3_q, f3_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  pick1;
  logic                  xfer;
  logic                  c_we;
  logic [DM_ADDRESS-1:0] c_addr;
  logic [DATA_W-1:0]     c_wdata;
  logic [2:0]            c_f3;
  logic                  c_ok;

  function automatic logic cmd_ok(input logic we, input logic [2:0] f3, input logic [1:0] a_lo);
    logic f3_legal;
    logic misaligned;
    f3_legal   = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                    : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((f3[1:0] == 2'b01) && a_lo[0]) || ((f3 == 3'b010) && (a_lo != 2'b00));
    return f3_legal && !misaligned;
  endfunction

  // Handshake: a port's command transfers on the edge where its req and ready are both high;
  // ready is only ever offered in IDLE, to the single winning port, and never depends on ready.
  always_comb begin
    pick1 = 1'b0;
`ifdef DMEM_ARB_RR_EN
    pick1 = req1 && (!req0 || !last_gnt_q);
`else
    pick1 = req1 && !req0;
`endif
    xfer    = (state_q == S_IDLE) && (req0 || req1);
    c_we    = pick1 ? we1    : we0;
    c_addr  = pick1 ? addr1  : addr0;
    c_wdata = pick1 ? wdata1 : wdata0;
    c_f3    = pick1 ? f3_1   : f3_0;
    c_ok    = cmd_ok(c_we, c_f3, c_addr[1:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (xfer) state_d = c_ok ? S_ACCESS : S_RESP;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready0   = 1'b0;
    ready1   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    done0    = 1'b0;
    done1    = 1'b0;
    err0     = 1'b0;
    err1     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready0 = req0 && !pick1;
        ready1 = pick1;
      end
      S_ACCESS: begin
        MemRead  = !we_q;
        MemWrite = we_q;
      end
      S_RESP: begin
        done0 = !gnt_q;
        done1 = gnt_q;
        err0  = !gnt_q && err_q;
        err1  = gnt_q && err_q;
      end
      default: ;
    endcase
  end

  // Command latch and read-data register; rejected commands clear rdata so RESP reports zero.
  always_comb begin
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    if (xfer) begin
      last_gnt_d = pick1;
      gnt_d      = pick1;
      we_d       = c_we;
      addr_d     = c_addr;
      wdata_d    = c_wdata;
      f3_d       = c_f3;
      err_d      = !c_ok;
      if (!c_ok) rdata_d = '0;
    end
    if ((state_q == S_ACCESS) && !we_q) rdata_d = rd;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      f3_q       <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign a            = addr_q;
  assign wd           = wdata_q;
  assign Funct3       = f3_q;
  assign rdata        = rdata_q;
  assign dbg_state    = state_q;
  assign dbg_last_gnt = last_gnt_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: byte-array datamemory model plus a reference memory and
// rdata predictor; directed cases followed by random single-port traffic.
module tb_dmem_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [2:0]    f3_0, f3_1;
  logic          ready0, ready1, done0, done1, err0, err1;
  logic [DW-1:0] rdata, wd, rd;
  logic          MemRead, MemWrite;
  logic [AW-1:0] a;
  logic [2:0]    Funct3;
  logic [1:0]    dbg_state;
  logic          dbg_last_gnt;

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_rdata;
  bit            last_port;
  logic [7:0]    mem [512];
  logic [7:0]    ref_mem [512];

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .f3_0(f3_0), .f3_1(f3_1),
    .ready0(ready0), .ready1(ready1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd),
    .dbg_state(dbg_state), .dbg_last_gnt(dbg_last_gnt)
  );

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b010:  return w;
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  // datamemory stand-in: combinational read, byte/half/word write on posedge
  assign rd = ext({mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]}, Funct3);

  always @(posedge clk) begin
    if (MemWrite) begin
      mem[a] <= wd[7:0];
      if (Funct3[1:0] != 2'b00) mem[a + 9'd1] <= wd[15:8];
      if (Funct3[1:0] == 2'b10) begin
        mem[a + 9'd2] <= wd[23:16];
        mem[a + 9'd3] <= wd[31:24];
      end
    end
  end

  function automatic int acc_size(input bit we, input logic [2:0] f3);
    if (f3[2] && (we || f3[1:0] != 2'b00 && f3[1:0] != 2'b01)) return 0;
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit ref_ok(input bit we, input logic [AW-1:0] addr, input logic [2:0] f3);
    int n;
    n = acc_size(we, f3);
    return (n != 0) && ((int'(addr) % n) == 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [AW-1:0] addr, input logic [2:0] f3);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = acc_size(1'b0, f3);
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [AW-1:0] addr, input logic [2:0] f3, input logic [31:0] d);
    int n;
    n = acc_size(1'b1, f3);
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(d >> (8 * i));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] d, input logic [2:0] f3);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = d; f3_1 = f3;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = d; f3_0 = f3;
    end
  endtask

  // Called at a negedge with both reqs low; returns at a negedge with the port idle again.
  task automatic do_txn(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] d, input logic [2:0] f3);
    int waited;
    bit ok;
    logic [DW-1:0] exp;
    ok = ref_ok(we, addr, f3);
    drive(port, we, addr, d, f3);
    waited = 0;
    #1;
    while (!(port ? ready1 : ready0) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    check("ready_timeout", 32'(waited < 20), 32'd1);
    check("ready_other", 32'(port ? ready0 : ready1), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (waited >= 20) return;
    last_port = port;
    if (!ok)     exp = 32'h0;
    else if (we) exp = model_rdata;
    else         exp = ref_load(addr, f3);
    if (ok && we) ref_store(addr, f3, d);
    model_rdata = exp;
    exp_q.push_back(exp);
    @(negedge clk);
    if (ok) begin
      check("access_memread", 32'(MemRead), 32'(!we));
      check("access_memwrite", 32'(MemWrite), 32'(we));
      check("access_addr", 32'(a), 32'(addr));
      check("access_f3", 32'(Funct3), 32'(f3));
      check("access_no_done", 32'(port ? done1 : done0), 32'd0);
      @(negedge clk);
    end
    check("resp_done", 32'(port ? done1 : done0), 32'd1);
    check("resp_done_other", 32'(port ? done0 : done1), 32'd0);
    check("resp_err", 32'(port ? err1 : err0), 32'(!ok));
    check("resp_no_strobe", 32'({MemRead, MemWrite}), 32'd0);
    check("resp_rdata", rdata, exp_q.pop_front());
    @(negedge clk);
    check("done_pulse_end", 32'({done0, done1}), 32'd0);
  endtask

  initial begin
    int grants;
    int cyc;
    bit exp_w;
    for (int i = 0; i < 512; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; f3_0 = '0; f3_1 = '0;
    model_rdata = '0;
    last_port = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rdata", rdata, 32'h0);
    check("rst_done_err", 32'({done0, done1, err0, err1}), 32'd0);
    check("rst_mem", 32'({MemRead, MemWrite}), 32'd0);
    check("rst_addr", 32'(a), 32'd0);
    check("rst_last_gnt", 32'(dbg_last_gnt), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a port-0 store's ACCESS cycle
    drive(1'b0, 1'b1, 9'h10, 32'hCAFE_F00D, 3'b010);
    #1;
    check("rst_case_ready", 32'(ready0), 32'd1);
    @(posedge clk); #1;
    req0 = 1'b0;
    check("rst_case_strobe", 32'(MemWrite), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_mem", 32'({MemRead, MemWrite}), 32'd0);
    check("rst_async_wd", wd, 32'h0);
    check("rst_async_done", 32'({done0, done1}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_done", 32'({done0, done1, err0, err1}), 32'd0);
    end
    reset_n = 1'b1;
    model_rdata = '0;
    last_port = 1'b1;
    @(negedge clk);
    check("rst_no_late_done", 32'({done0, done1}), 32'd0);

    // both ports requesting continuously: grant order
    drive(1'b0, 1'b0, 9'h20, 32'h0, 3'b010);
    drive(1'b1, 1'b0, 9'h24, 32'h0, 3'b010);
    grants = 0;
    cyc = 0;
    while (grants < 4 && cyc < 60) begin
      @(negedge clk);
      if (ready0 || ready1) begin
`ifdef DMEM_ARB_RR_EN
        exp_w = !last_port;
`else
        exp_w = 1'b0;
`endif
        check("arb_winner", 32'(ready1), 32'(exp_w));
        check("arb_onehot", 32'(ready0 && ready1), 32'd0);
        last_port = ready1;
        model_rdata = ref_load(ready1 ? 9'h24 : 9'h20, 3'b010);
        grants++;
      end
      cyc++;
    end
    check("arb_grant_count", 32'(grants), 32'd4);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge clk);
    check("arb_rdata", rdata, model_rdata);

    // store/load round trip, byte sign handling, rejects, illegal store
    do_txn(1'b0, 1'b1, 9'h10, 32'hDEAD_BEEF, 3'b010);
    do_txn(1'b0, 1'b0, 9'h10, 32'h0, 3'b010);
    do_txn(1'b1, 1'b1, 9'h13, 32'h0000_0080, 3'b000);
    do_txn(1'b1, 1'b0, 9'h13, 32'h0, 3'b000);
    do_txn(1'b1, 1'b0, 9'h13, 32'h0, 3'b100);
    do_txn(1'b0, 1'b0, 9'h12, 32'h0, 3'b010);
    do_txn(1'b1, 1'b0, 9'h11, 32'h0, 3'b001);
    do_txn(1'b1, 1'b1, 9'h40, 32'h1234_5678, 3'b100);
    do_txn(1'b1, 1'b1, 9'h40, 32'h1234_5678, 3'b010);
    do_txn(1'b0, 1'b0, 9'h40, 32'h0, 3'b101);
    do_txn(1'b0, 1'b0, 9'h1FC, 32'h0, 3'b010);

    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] ad;
      ad = AW'($urandom_range(0, 511));
      if ($urandom_range(0, 1) == 1) ad = ad & ~9'h3;
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, $urandom,
             3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
